// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the fetch/data memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic [2:0] {
    StIdle,
    StBusyI,
    StBusyD,
    StDoneI,
    StDoneD,
    StFlushI
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data ports onto one req/ack backing memory port; data wins ties
// and a started transaction is never preempted.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_arb_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                imem_req,
  input  logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_flush,
  output logic [DATA_W-1:0]   imem_rdata,
  output logic                imem_ready,
  input  logic                dmem_use,
  input  logic                dmem_we,
  input  logic [ADDR_W-1:0]   dmem_addr,
  input  logic [DATA_W-1:0]   dmem_wdata,
  input  logic [DATA_W/8-1:0] dmem_be,
  output logic [DATA_W-1:0]   dmem_rdata,
  output logic                dmem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack
);
  import mem_arb_pkg::*;

  arb_state_e            state_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [DATA_W-1:0]     mem_wdata_q;
  logic [DATA_W/8-1:0]   mem_be_q;
  logic [DATA_W-1:0]     imem_rdata_q;
  logic [DATA_W-1:0]     dmem_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      imem_rdata_q <= '0;
      dmem_rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (dmem_use) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= dmem_we;
            mem_addr_q  <= dmem_addr;
            mem_wdata_q <= dmem_wdata;
            mem_be_q    <= dmem_be;
            state_q     <= StBusyD;
          end else if (imem_req) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= imem_addr;
            mem_be_q   <= '1;
            state_q    <= StBusyI;
          end
        end
        StBusyI: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            // A redirect in the ack cycle discards the word and skips the ready pulse.
            if (imem_flush) begin
              state_q <= StIdle;
            end else begin
              imem_rdata_q <= mem_rdata;
              state_q      <= StDoneI;
            end
          end else if (imem_flush) begin
            state_q <= StFlushI;
          end
        end
        StBusyD: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            if (!mem_we_q) begin
              dmem_rdata_q <= mem_rdata;
            end
            state_q <= StDoneD;
          end
        end
        StFlushI: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= StIdle;
          end
        end
        StDoneI, StDoneD: begin
          state_q <= StIdle;
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  assign imem_ready = ~imem_req | (state_q == StDoneI);
  assign dmem_ready = ~dmem_use | (state_q == StDoneD);
  assign imem_rdata = imem_rdata_q;
  assign dmem_rdata = dmem_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; backing memory acks are driven by hand.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_flush;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        dmem_use;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_checks;
  int n_fail;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_flush(imem_flush),
    .imem_rdata(imem_rdata),
    .imem_ready(imem_ready),
    .dmem_use  (dmem_use),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_be   (dmem_be),
    .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    imem_req   = 1'b1;
    imem_addr  = 32'h0;
    imem_flush = 1'b0;
    dmem_use   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = 32'h0;
    dmem_wdata = 32'h0;
    dmem_be    = 4'h0;
    mem_rdata  = 32'h0;
    mem_ack    = 1'b0;

    // Reset values; ready follows request while held in reset
    tick();
    settle();
    check_eq("rst_imem_ready", {63'd0, imem_ready}, 64'd0);
    check_eq("rst_dmem_ready", {63'd0, dmem_ready}, 64'd1);
    check_eq("rst_mem_req", {63'd0, mem_req}, 64'd0);
    check_eq("rst_mem_bus", {mem_we, mem_be, mem_addr, 27'd0}, 64'd0);
    check_eq("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
    check_eq("rst_rdata", {imem_rdata, dmem_rdata}, 64'd0);
    imem_req = 1'b0;
    rst      = 1'b0;

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      settle();
      check_eq("idle_ready", {62'd0, imem_ready, dmem_ready}, 64'd3);
      check_eq("idle_mem_req", {63'd0, mem_req}, 64'd0);
    end

    // Single fetch at 0x100, ack in the first bus cycle
    imem_req  = 1'b1;
    imem_addr = 32'h100;
    settle();
    check_eq("f_c0_ready", {63'd0, imem_ready}, 64'd0);
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    settle();
    check_eq("f_c1_req", {63'd0, mem_req}, 64'd1);
    check_eq("f_c1_addr", {32'd0, mem_addr}, 64'h100);
    check_eq("f_c1_we_be", {59'd0, mem_we, mem_be}, 64'hF);
    check_eq("f_c1_ready", {63'd0, imem_ready}, 64'd0);
    tick();
    mem_ack = 1'b0;
    settle();
    check_eq("f_c2_ready", {63'd0, imem_ready}, 64'd1);
    check_eq("f_c2_rdata", {32'd0, imem_rdata}, 64'hDEADBEEF);
    check_eq("f_c2_req", {63'd0, mem_req}, 64'd0);
    imem_req = 1'b0;
    tick();

    // Simultaneous fetch and load: load first, ack latency 3
    imem_req  = 1'b1;
    imem_addr = 32'h100;
    dmem_use  = 1'b1;
    dmem_we   = 1'b0;
    dmem_addr = 32'h2000;
    settle();
    check_eq("s_c0_ready", {62'd0, imem_ready, dmem_ready}, 64'd0);
    tick();
    settle();
    check_eq("s_c1_req", {63'd0, mem_req}, 64'd1);
    check_eq("s_c1_addr", {32'd0, mem_addr}, 64'h2000);
    check_eq("s_c1_we", {63'd0, mem_we}, 64'd0);
    tick();
    settle();
    check_eq("s_c2_ready", {62'd0, imem_ready, dmem_ready}, 64'd0);
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    settle();
    check_eq("s_c3_ready", {62'd0, imem_ready, dmem_ready}, 64'd0);
    tick();
    mem_ack = 1'b0;
    settle();
    check_eq("s_c4_dready", {63'd0, dmem_ready}, 64'd1);
    check_eq("s_c4_iready", {63'd0, imem_ready}, 64'd0);
    check_eq("s_c4_drdata", {32'd0, dmem_rdata}, 64'hCAFEF00D);
    dmem_use = 1'b0;
    tick();
    settle();
    check_eq("s_c5_req", {63'd0, mem_req}, 64'd0);
    check_eq("s_c5_iready", {63'd0, imem_ready}, 64'd0);
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'h11111111;
    settle();
    check_eq("s_c6_req", {63'd0, mem_req}, 64'd1);
    check_eq("s_c6_addr", {32'd0, mem_addr}, 64'h100);
    check_eq("s_c6_iready", {63'd0, imem_ready}, 64'd0);
    tick();
    mem_ack = 1'b0;
    settle();
    check_eq("s_c7_iready", {63'd0, imem_ready}, 64'd1);
    check_eq("s_c7_irdata", {32'd0, imem_rdata}, 64'h11111111);
    imem_req = 1'b0;
    tick();

    // Store 0xA5A5A5A5, be 0011, to 0x40
    dmem_use   = 1'b1;
    dmem_we    = 1'b1;
    dmem_addr  = 32'h40;
    dmem_wdata = 32'hA5A5A5A5;
    dmem_be    = 4'b0011;
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'hBADBAD00;
    settle();
    check_eq("st_bus", {27'd0, mem_req, mem_we, mem_be, 32'd0}, {27'd0, 1'b1, 1'b1, 4'b0011, 32'd0});
    check_eq("st_addr_data", {mem_addr, mem_wdata}, {32'h40, 32'hA5A5A5A5});
    check_eq("st_c1_ready", {63'd0, dmem_ready}, 64'd0);
    tick();
    mem_ack = 1'b0;
    settle();
    check_eq("st_c2_ready", {63'd0, dmem_ready}, 64'd1);
    check_eq("st_rdata_kept", {32'd0, dmem_rdata}, 64'hCAFEF00D);
    dmem_use = 1'b0;
    dmem_we  = 1'b0;
    tick();

    // Fetch flushed while in flight; the redirect target is fetched after the ack
    imem_req  = 1'b1;
    imem_addr = 32'h300;
    tick();
    imem_flush = 1'b1;
    imem_addr  = 32'h400;
    settle();
    check_eq("fl_c1_addr", {32'd0, mem_addr}, 64'h300);
    tick();
    imem_flush = 1'b0;
    mem_ack    = 1'b1;
    mem_rdata  = 32'h12345678;
    settle();
    check_eq("fl_c2_req", {63'd0, mem_req}, 64'd1);
    check_eq("fl_c2_ready", {63'd0, imem_ready}, 64'd0);
    tick();
    mem_ack = 1'b0;
    settle();
    check_eq("fl_c3_ready", {63'd0, imem_ready}, 64'd0);
    check_eq("fl_c3_rdata", {32'd0, imem_rdata}, 64'h11111111);
    check_eq("fl_c3_req", {63'd0, mem_req}, 64'd0);
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'h44444444;
    settle();
    check_eq("fl_c4_req", {63'd0, mem_req}, 64'd1);
    check_eq("fl_c4_addr", {32'd0, mem_addr}, 64'h400);
    tick();
    mem_ack = 1'b0;
    settle();
    check_eq("fl_c5_ready", {63'd0, imem_ready}, 64'd1);
    check_eq("fl_c5_rdata", {32'd0, imem_rdata}, 64'h44444444);
    imem_req = 1'b0;
    tick();

    // Flush coinciding with the ack: back to idle, no ready, data not captured
    imem_req  = 1'b1;
    imem_addr = 32'h500;
    tick();
    imem_flush = 1'b1;
    mem_ack    = 1'b1;
    mem_rdata  = 32'h55555555;
    tick();
    imem_flush = 1'b0;
    mem_ack    = 1'b0;
    settle();
    check_eq("fa_ready", {63'd0, imem_ready}, 64'd0);
    check_eq("fa_rdata", {32'd0, imem_rdata}, 64'h44444444);
    check_eq("fa_req", {63'd0, mem_req}, 64'd0);
    imem_req = 1'b0;
    tick();

    // Reset during a load, then a stray ack
    dmem_use  = 1'b1;
    dmem_we   = 1'b0;
    dmem_addr = 32'h600;
    tick();
    settle();
    check_eq("rb_c1_req", {63'd0, mem_req}, 64'd1);
    rst      = 1'b1;
    dmem_use = 1'b0;
    settle();
    check_eq("rb_async_req", {63'd0, mem_req}, 64'd0);
    check_eq("rb_async_addr", {32'd0, mem_addr}, 64'd0);
    check_eq("rb_async_rdata", {imem_rdata, dmem_rdata}, 64'd0);
    tick();
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h66666666;
    tick();
    mem_ack = 1'b0;
    settle();
    check_eq("rb_ack_req", {63'd0, mem_req}, 64'd0);
    check_eq("rb_ack_rdata", {32'd0, dmem_rdata}, 64'd0);
    check_eq("rb_ack_ready", {62'd0, imem_ready, dmem_ready}, 64'd3);
    // A fresh fetch is accepted straight away, proving the FSM is idle
    imem_req  = 1'b1;
    imem_addr = 32'h700;
    tick();
    settle();
    check_eq("rb_new_req", {63'd0, mem_req}, 64'd1);
    check_eq("rb_new_addr", {32'd0, mem_addr}, 64'h700);
    imem_req = 1'b0;
    mem_ack  = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
